dest_addr_pipe: RTL and testbench

Parametrised destination-address segment chain for the RV32I core. It carries the register-file and CSR destination addresses, with their write-enables, from EX through a configurable number of downstream stages (default MEM, WB). Each stage has its own bubble and flush control. Every cycle it compares the in-flight destinations against the source addresses of the instruction in EX and reports the youngest matching stage to the forwarding/hazard unit.

---
 rtl/dest_addr_pipe.sv | 157 +++++++++++++++
 tb/tb_dest_addr_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_addr_pipe.sv
// Destination-address segment chain from EX through STAGES downstream stages, with per-stage
// bubble/flush and youngest-match lookup for forwarding. Define DEST_PIPE_CSR_EN to carry CSR destinations.
module dest_addr_pipe #(
    parameter int STAGES = 2,
    parameter int REG_W  = 5,
    parameter int CSR_W  = 12,
    parameter int SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [STAGES-1:0]         bubble,
    input  logic [STAGES-1:0]         flush,
    input  logic [REG_W-1:0]          reg_dest_ex,
    input  logic                      reg_we_ex,
    input  logic [CSR_W-1:0]          csr_dest_ex,
    input  logic                      csr_we_ex,
    output logic [STAGES*REG_W-1:0]   reg_dest_q,
    output logic [STAGES-1:0]         reg_we_q,
    output logic [STAGES*CSR_W-1:0]   csr_dest_q,
    output logic [STAGES-1:0]         csr_we_q,
    input  logic [REG_W-1:0]          rs1_ex,
    input  logic [REG_W-1:0]          rs2_ex,
    input  logic [CSR_W-1:0]          csr_src_ex,
    output logic                      rs1_hit,
    output logic                      rs2_hit,
    output logic                      csr_hit,
    output logic [SEL_W-1:0]          rs1_sel,
    output logic [SEL_W-1:0]          rs2_sel,
    output logic [SEL_W-1:0]          csr_sel
);

    logic [STAGES*REG_W-1:0] reg_src_s;
    logic [STAGES-1:0]       reg_we_src_s;
    logic [STAGES*REG_W-1:0] reg_dest_d;
    logic [STAGES-1:0]       reg_we_d;
    logic [STAGES-1:0]       rs1_match_s;
    logic [STAGES-1:0]       rs2_match_s;

    // Stage i loads from EX (i = 0) or from stage i-1; the top stage feeds nothing.
    if (STAGES > 1) begin : g_chain
        assign reg_src_s    = {reg_dest_q[(STAGES-1)*REG_W-1:0], reg_dest_ex};
        assign reg_we_src_s = {reg_we_q[STAGES-2:0], reg_we_ex};
    end else begin : g_single
        assign reg_src_s    = reg_dest_ex;
        assign reg_we_src_s = reg_we_ex;
    end

    // Next register-destination state: bubble holds, then flush clears, else load (x0 never writes).
    always_comb begin
        reg_dest_d = reg_dest_q;
        reg_we_d   = reg_we_q;
        for (int i = 0; i < STAGES; i++) begin
            if (bubble[i]) begin
                reg_dest_d[i*REG_W +: REG_W] = reg_dest_q[i*REG_W +: REG_W];
                reg_we_d[i]                  = reg_we_q[i];
            end else if (flush[i]) begin
                reg_dest_d[i*REG_W +: REG_W] = '0;
                reg_we_d[i]                  = 1'b0;
            end else begin
                reg_dest_d[i*REG_W +: REG_W] = reg_src_s[i*REG_W +: REG_W];
                reg_we_d[i]                  = reg_we_src_s[i] && (reg_src_s[i*REG_W +: REG_W] != '0);
            end
        end
    end

    // Register-destination segment flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_dest_q <= '0;
            reg_we_q   <= '0;
        end else begin
            reg_dest_q <= reg_dest_d;
            reg_we_q   <= reg_we_d;
        end
    end

    // Register-source match; scanning downward leaves the lowest (youngest) matching stage selected.
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        for (int i = 0; i < STAGES; i++) begin
            rs1_match_s[i] = reg_we_q[i] && (reg_dest_q[i*REG_W +: REG_W] == rs1_ex) && (rs1_ex != '0);
            rs2_match_s[i] = reg_we_q[i] && (reg_dest_q[i*REG_W +: REG_W] == rs2_ex) && (rs2_ex != '0);
        end
        for (int i = STAGES - 1; i >= 0; i--) begin
            rs1_sel = rs1_match_s[i] ? SEL_W'(i) : rs1_sel;
            rs2_sel = rs2_match_s[i] ? SEL_W'(i) : rs2_sel;
        end
        rs1_hit = |rs1_match_s;
        rs2_hit = |rs2_match_s;
    end

`ifdef DEST_PIPE_CSR_EN
    logic [STAGES*CSR_W-1:0] csr_src_s;
    logic [STAGES-1:0]       csr_we_src_s;
    logic [STAGES*CSR_W-1:0] csr_dest_d;
    logic [STAGES-1:0]       csr_we_d;
    logic [STAGES-1:0]       csr_match_s;

    if (STAGES > 1) begin : g_csr_chain
        assign csr_src_s    = {csr_dest_q[(STAGES-1)*CSR_W-1:0], csr_dest_ex};
        assign csr_we_src_s = {csr_we_q[STAGES-2:0], csr_we_ex};
    end else begin : g_csr_single
        assign csr_src_s    = csr_dest_ex;
        assign csr_we_src_s = csr_we_ex;
    end

    // Next CSR-destination state; CSR 0 is an ordinary address.
    always_comb begin
        csr_dest_d = csr_dest_q;
        csr_we_d   = csr_we_q;
        for (int i = 0; i < STAGES; i++) begin
            if (bubble[i]) begin
                csr_dest_d[i*CSR_W +: CSR_W] = csr_dest_q[i*CSR_W +: CSR_W];
                csr_we_d[i]                  = csr_we_q[i];
            end else if (flush[i]) begin
                csr_dest_d[i*CSR_W +: CSR_W] = '0;
                csr_we_d[i]                  = 1'b0;
            end else begin
                csr_dest_d[i*CSR_W +: CSR_W] = csr_src_s[i*CSR_W +: CSR_W];
                csr_we_d[i]                  = csr_we_src_s[i];
            end
        end
    end

    // CSR-destination segment flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_dest_q <= '0;
            csr_we_q   <= '0;
        end else begin
            csr_dest_q <= csr_dest_d;
            csr_we_q   <= csr_we_d;
        end
    end

    // CSR-source match with youngest-stage priority.
    always_comb begin
        csr_sel = '0;
        for (int i = 0; i < STAGES; i++) begin
            csr_match_s[i] = csr_we_q[i] && (csr_dest_q[i*CSR_W +: CSR_W] == csr_src_ex);
        end
        for (int i = STAGES - 1; i >= 0; i--) begin
            csr_sel = csr_match_s[i] ? SEL_W'(i) : csr_sel;
        end
        csr_hit = |csr_match_s;
    end
`else
    logic unused_csr_s;
    assign unused_csr_s = ^{csr_dest_ex, csr_we_ex, csr_src_ex};
    assign csr_dest_q   = '0;
    assign csr_we_q     = '0;
    assign csr_hit      = 1'b0;
    assign csr_sel      = '0;
`endif

endmodule

// File: tb/tb_dest_addr_pipe.sv
// Bench for dest_addr_pipe: a 2-stage and a 4-stage instance checked against a stage-array model,
// directed scenarios followed by randomized traffic.
module tb_dest_addr_pipe;
    localparam int REG_W = 5;
    localparam int CSR_W = 12;
`ifdef DEST_PIPE_CSR_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [1:0] b2 = '0, f2 = '0;
    logic [3:0] b4 = '0, f4 = '0;
    logic [REG_W-1:0] reg_dest_ex = '0, rs1_ex = '0, rs2_ex = '0;
    logic reg_we_ex = 1'b0, csr_we_ex = 1'b0;
    logic [CSR_W-1:0] csr_dest_ex = '0, csr_src_ex = '0;

    logic [9:0]  rd2;  logic [1:0] rw2;  logic [23:0] cd2;  logic [1:0] cw2;
    logic [19:0] rd4;  logic [3:0] rw4;  logic [47:0] cd4;  logic [3:0] cw4;
    logic h1_2, h2_2, hc_2, h1_4, h2_4, hc_4;
    logic [1:0] s1_2, s2_2, sc_2, s1_4, s2_4, sc_4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // model: [instance][stage]
    int m_rd [2][4];
    bit m_rw [2][4];
    int m_cd [2][4];
    bit m_cw [2][4];
    int depth [2] = '{2, 4};

    always #5 clk = ~clk;

    dest_addr_pipe #(.STAGES(2), .REG_W(REG_W), .CSR_W(CSR_W), .SEL_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bubble(b2), .flush(f2),
        .reg_dest_ex(reg_dest_ex), .reg_we_ex(reg_we_ex),
        .csr_dest_ex(csr_dest_ex), .csr_we_ex(csr_we_ex),
        .reg_dest_q(rd2), .reg_we_q(rw2), .csr_dest_q(cd2), .csr_we_q(cw2),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .csr_src_ex(csr_src_ex),
        .rs1_hit(h1_2), .rs2_hit(h2_2), .csr_hit(hc_2),
        .rs1_sel(s1_2), .rs2_sel(s2_2), .csr_sel(sc_2)
    );

    dest_addr_pipe #(.STAGES(4), .REG_W(REG_W), .CSR_W(CSR_W), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bubble(b4), .flush(f4),
        .reg_dest_ex(reg_dest_ex), .reg_we_ex(reg_we_ex),
        .csr_dest_ex(csr_dest_ex), .csr_we_ex(csr_we_ex),
        .reg_dest_q(rd4), .reg_we_q(rw4), .csr_dest_q(cd4), .csr_we_q(cw4),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .csr_src_ex(csr_src_ex),
        .rs1_hit(h1_4), .rs2_hit(h2_4), .csr_hit(hc_4),
        .rs1_sel(s1_4), .rs2_sel(s2_4), .csr_sel(sc_4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_rd[k][i] = 0; m_rw[k][i] = 1'b0; m_cd[k][i] = 0; m_cw[k][i] = 1'b0;
            end
    endtask

    // Update oldest stage first so each stage still sees its predecessor's pre-edge contents.
    task automatic model_step();
        bit bb, ff;
        for (int k = 0; k < 2; k++)
            for (int i = depth[k] - 1; i >= 0; i--) begin
                bb = (k == 0) ? b2[i] : b4[i];
                ff = (k == 0) ? f2[i] : f4[i];
                if (bb) begin
                end else if (ff) begin
                    m_rd[k][i] = 0; m_rw[k][i] = 1'b0; m_cd[k][i] = 0; m_cw[k][i] = 1'b0;
                end else if (i == 0) begin
                    m_rd[k][0] = int'(reg_dest_ex);
                    m_rw[k][0] = reg_we_ex && (reg_dest_ex != 0);
                    m_cd[k][0] = int'(csr_dest_ex);
                    m_cw[k][0] = csr_we_ex;
                end else begin
                    m_rd[k][i] = m_rd[k][i-1];
                    m_rw[k][i] = m_rw[k][i-1] && (m_rd[k][i-1] != 0);
                    m_cd[k][i] = m_cd[k][i-1];
                    m_cw[k][i] = m_cw[k][i-1];
                end
            end
    endtask

    // kind 0 = rs1, 1 = rs2, 2 = csr; first (youngest) matching stage wins.
    function automatic void exp_match(input int k, input int kind, output bit hit, output int sel);
        int src;
        bit m;
        src = (kind == 0) ? int'(rs1_ex) : (kind == 1) ? int'(rs2_ex) : int'(csr_src_ex);
        hit = 1'b0;
        sel = 0;
        for (int i = 0; i < depth[k]; i++) begin
            if (kind < 2) m = m_rw[k][i] && (m_rd[k][i] == src) && (src != 0);
            else          m = CSR_EN && m_cw[k][i] && (m_cd[k][i] == src);
            if (m && !hit) begin
                hit = 1'b1;
                sel = i;
            end
        end
    endfunction

    task automatic check_all(input string ph);
        logic [19:0] g_rd; logic [3:0] g_rw; logic [47:0] g_cd; logic [3:0] g_cw;
        logic [2:0] g_hit; logic [5:0] g_sel;
        bit eh; int es;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                g_rd = {10'd0, rd2}; g_rw = {2'd0, rw2}; g_cd = {24'd0, cd2}; g_cw = {2'd0, cw2};
                g_hit = {hc_2, h2_2, h1_2}; g_sel = {sc_2, s2_2, s1_2};
            end else begin
                g_rd = rd4; g_rw = rw4; g_cd = cd4; g_cw = cw4;
                g_hit = {hc_4, h2_4, h1_4}; g_sel = {sc_4, s2_4, s1_4};
            end
            for (int i = 0; i < depth[k]; i++) begin
                check_eq($sformatf("%s_d%0d_rd%0d", ph, depth[k], i), 32'(g_rd[i*5 +: 5]), 32'(m_rd[k][i]));
                check_eq($sformatf("%s_d%0d_rw%0d", ph, depth[k], i), 32'(g_rw[i]), 32'(m_rw[k][i]));
                check_eq($sformatf("%s_d%0d_cd%0d", ph, depth[k], i), 32'(g_cd[i*12 +: 12]),
                         CSR_EN ? 32'(m_cd[k][i]) : 32'd0);
                check_eq($sformatf("%s_d%0d_cw%0d", ph, depth[k], i), 32'(g_cw[i]),
                         CSR_EN ? 32'(m_cw[k][i]) : 32'd0);
            end
            for (int kind = 0; kind < 3; kind++) begin
                exp_match(k, kind, eh, es);
                check_eq($sformatf("%s_d%0d_hit%0d", ph, depth[k], kind), 32'(g_hit[kind]), 32'(eh));
                check_eq($sformatf("%s_d%0d_sel%0d", ph, depth[k], kind), 32'(g_sel[kind*2 +: 2]), 32'(es));
            end
        end
    endtask

    // Check current state against current inputs, then take one clock edge.
    task automatic step(input string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("rst");
        check_eq("rst_we4_async", 32'(rw4), 32'd0);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic set_ex(input int d, input bit we);
        reg_dest_ex = REG_W'(d);
        reg_we_ex   = we;
    endtask

    initial begin
        model_clear();
        #7;
        do_reset();

        set_ex(5, 1'b1);
        step("prop");
        check_eq("prop_s0", 32'(rd2[4:0]), 32'd5);
        step("prop");
        check_eq("prop_s1", 32'(rd2[9:5]), 32'd5);
        check_eq("prop_we", 32'(rw2), 32'd3);

        set_ex(0, 1'b1);
        step("x0");
        check_eq("x0_we0", 32'(rw2[0]), 32'd0);
        rs1_ex = '0;
        #1;
        check_eq("x0_rs1_hit", 32'(h1_2), 32'd0);

        set_ex(7, 1'b1);
        step("young");
        step("young");
        rs1_ex = 5'd7;
        #1;
        check_eq("young_hit", 32'(h1_2), 32'd1);
        check_eq("young_sel0", 32'(s1_2), 32'd0);
        b2 = 2'b10; b4 = 4'b0010;
        set_ex(3, 1'b1);
        step("young");
        check_eq("young_sel1", 32'(s1_2), 32'd1);
        b2 = '0; b4 = '0;

        set_ex(9, 1'b1);
        step("bf");
        b2 = 2'b01; f2 = 2'b01; b4 = 4'b0001; f4 = 4'b0001;
        set_ex(4, 1'b1);
        step("bf");
        check_eq("bf_hold_s0", 32'(rd2[4:0]), 32'd9);
        check_eq("bf_load_s1", 32'(rd2[9:5]), 32'd9);
        b2 = '0; b4 = '0;
        step("bf");
        check_eq("fl_s0", 32'(rd2[4:0]), 32'd0);
        check_eq("fl_we0", 32'(rw2[0]), 32'd0);
        check_eq("fl_s1", 32'(rd2[9:5]), 32'd9);
        f2 = '0; f4 = '0;

        csr_dest_ex = 12'h300; csr_we_ex = 1'b1;
        step("csr");
        csr_src_ex = 12'h300;
        #1;
        check_eq("csr_hit", 32'(hc_2), 32'(CSR_EN));
        check_eq("csr_sel", 32'(sc_2), 32'd0);
        csr_we_ex = 1'b0;

        do_reset();
        rs1_ex = '0; rs2_ex = '0;
        set_ex(6, 1'b1);
        step("depth");
        set_ex(0, 1'b0);
        for (int c = 0; c < 3; c++) step("depth");
        rs2_ex = 5'd6;
        #1;
        check_eq("depth_s3", 32'(rd4[19:15]), 32'd6);
        check_eq("depth_hit", 32'(h2_4), 32'd1);
        check_eq("depth_sel3", 32'(s2_4), 32'd3);

        for (int c = 0; c < 400; c++) begin
            if (c % 137 == 136) do_reset();
            b2 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            f2 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            b4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            f4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            set_ex($urandom_range(0, 7), 1'($urandom));
            rs1_ex = REG_W'($urandom_range(0, 7));
            rs2_ex = REG_W'($urandom_range(0, 7));
            csr_dest_ex = 12'h300 + CSR_W'($urandom_range(0, 2));
            csr_we_ex = 1'($urandom);
            csr_src_ex = 12'h300 + CSR_W'($urandom_range(0, 2));
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
